// File: rtl/fixed_point_pkg.sv
// Shared fixed-point constants and formatting helpers (round, saturate).
// Helpers work on a wide signed type; callers sign-extend in and slice out.
package fixed_point_pkg;

    localparam int unsigned MODE_EXTEND   = 0;
    localparam int unsigned MODE_SATURATE = 1;
    localparam int unsigned MaxWidth      = 32;

    typedef logic signed [MaxWidth:0] wide_t;

    typedef struct packed {
        wide_t value;
        logic  overflow;
    } sat_t;

    // Arithmetic halve; when en is set, the dropped LSB is added back (round half up).
    function automatic wide_t round_half_up(input wide_t v, input logic en);
        wide_t half;
        half = v >>> 1;
        if (en && v[0]) begin
            half = half + wide_t'(1);
        end
        return half;
    endfunction

    // Clamp v into the signed range of a width-bit word.
    function automatic sat_t saturate(input wide_t v, input int unsigned width);
        wide_t one;
        wide_t hi;
        wide_t lo;
        sat_t  r;
        one        = wide_t'(1);
        hi         = (one <<< (width - 1)) - one;
        lo         = -hi - one;
        r.overflow = 1'b1;
        if (v > hi) begin
            r.value = hi;
        end else if (v < lo) begin
            r.value = lo;
        end else begin
            r.value    = v;
            r.overflow = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fixed_point_addsub_lane.sv
// One lane: stage 1 computes the exact WIDTH+1 bit sum/difference,
// stage 2 formats it (extend-and-halve or saturate) into registered outputs.
module fixed_point_addsub_lane
    import fixed_point_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned MODE  = 0,
    parameter int unsigned ROUND = 0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             overflow_o
);

    logic signed [WIDTH:0] a_ext;
    logic signed [WIDTH:0] b_ext;
    logic signed [WIDTH:0] full_d;
    logic signed [WIDTH:0] full_q;
    wide_t                 full_wide;
    wide_t                 fmt_in;
    sat_t                  fmt;
    logic [WIDTH-1:0]      sum_d;
    logic [WIDTH-1:0]      sum_q;
    logic                  ovf_d;
    logic                  ovf_q;
    logic                  unused_fmt_hi;

    always_comb begin
        a_ext  = {a_i[WIDTH-1], a_i};
        b_ext  = {b_i[WIDTH-1], b_i};
        full_d = sub_i ? (a_ext - b_ext) : (a_ext + b_ext);
    end

    always_comb begin
        full_wide = {{(MaxWidth - WIDTH){full_q[WIDTH]}}, full_q};
        if (MODE == MODE_EXTEND) begin
            fmt_in = round_half_up(full_wide, ROUND != 0);
        end else begin
            fmt_in = full_wide;
        end
        // In extend mode only a rounded-up 2^WIDTH-1 can leave the range.
        fmt   = saturate(fmt_in, WIDTH);
        sum_d = fmt.value[WIDTH-1:0];
        ovf_d = fmt.overflow;
    end

    assign unused_fmt_hi = ^fmt.value[MaxWidth:WIDTH];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            full_q <= '0;
            sum_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (en_i) begin
            full_q <= full_d;
            sum_q  <= sum_d;
            ovf_q  <= ovf_d;
        end
    end

    assign sum_o      = sum_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/fixed_point_addsub_pipe.sv
// Multi-lane two-stage signed fixed-point adder/subtractor with valid/ready.
// A single global stall moves both stages together; lanes hold only data.
module fixed_point_addsub_pipe
    import fixed_point_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned LANES = 1,
    parameter int unsigned MODE  = 0,
    parameter int unsigned ROUND = 0
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   sub_i,
    input  logic [LANES*WIDTH-1:0] a_i,
    input  logic [LANES*WIDTH-1:0] b_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [LANES*WIDTH-1:0] sum_o,
    output logic [LANES-1:0]       overflow_o
);

    if (FRAC >= WIDTH || WIDTH < 2 || WIDTH >= MaxWidth || MODE > MODE_SATURATE ||
        LANES < 1) begin : gen_param_check
        $error("fixed_point_addsub_pipe: unsupported parameter combination");
    end

    logic advance;
    logic s1_valid_d;
    logic s1_valid_q;
    logic out_valid_d;
    logic out_valid_q;

    assign advance    = !out_valid_q || out_ready_i;
    assign in_ready_o = advance;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        if (advance) begin
            s1_valid_d  = in_valid_i;
            out_valid_d = s1_valid_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid_o = out_valid_q;

    for (genvar i = 0; i < LANES; i++) begin : gen_lane
        fixed_point_addsub_lane #(
            .WIDTH(WIDTH),
            .MODE (MODE),
            .ROUND(ROUND)
        ) u_lane (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .en_i      (advance),
            .sub_i     (sub_i),
            .a_i       (a_i[i*WIDTH +: WIDTH]),
            .b_i       (b_i[i*WIDTH +: WIDTH]),
            .sum_o     (sum_o[i*WIDTH +: WIDTH]),
            .overflow_o(overflow_o[i])
        );
    end

endmodule
